uart_zu_lcd: RTL and testbench

UART_ZU_LCD -- requirements
Module: uart_zu_lcd

---
 rtl/uart_lcd_pkg.sv | 33 +++
 rtl/uart_rx.sv | 95 +++++++++
 rtl/uart_zu_lcd.sv | 174 +++++++++++++++++
 tb/tb_uart_zu_lcd.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_lcd_pkg.sv
// Shared constants for the UART-to-character-LCD bridge: HD44780 commands,
// write-cycle timing and the state encodings of the receiver and LCD sequencer.
package uart_lcd_pkg;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    localparam int T_SETUP    = 5;
    localparam int T_PULSE    = 50;
    localparam int T_HOLD     = 5;
    localparam int T_WAIT_WR  = 5_000;
    localparam int T_WAIT_CLR = 200_000;

    typedef enum logic [2:0] {
        PWRUP, INIT_CMD, WR_SETUP, WR_PULSE, WR_HOLD, WR_WAIT, IDLE, LINE_CMD
    } lcd_state_t;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNC_SET;
            2'd1:    return CMD_DISP_ON;
            2'd2:    return CMD_CLEAR;
            default: return CMD_ENTRY;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, half-bit start validation,
// centre sampling, one-cycle valid pulse for frames with a good stop bit.
module uart_rx #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid
);
    import uart_lcd_pkg::*;

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);

    logic          rxd_p0, rxd_p1, rxd_p2;
    rx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          valid_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_p0  <= 1'b1;
            rxd_p1  <= 1'b1;
            rxd_p2  <= 1'b1;
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            valid   <= 1'b0;
        end else begin
            rxd_p0  <= rxd;
            rxd_p1  <= rxd_p0;
            rxd_p2  <= rxd_p1;
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            valid   <= valid_n;
        end
    end

    always_ff @(posedge clk) begin
        shift <= shift_n;
    end

    assign data = shift;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        valid_n   = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_n     = '0;
                bit_idx_n = '0;
                if (rxd_p2 && !rxd_p1)
                    state_n = RX_START;
            end
            // A low that does not survive to mid-bit is a glitch, not a start bit
            RX_START: begin
                if (cnt == CW'(HALF - 1)) begin
                    cnt_n   = '0;
                    state_n = rxd_p1 ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_n     = '0;
                    shift_n   = {rxd_p1, shift[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        state_n = RX_STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_n   = '0;
                    valid_n = rxd_p1;
                    state_n = RX_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/uart_zu_lcd.sv
// UART-to-HD44780 bridge: initialises the LCD after power-up, then writes each
// received byte as a character, moving to line 2 at column 16 and home at 32.
module uart_zu_lcd #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int T_POWERUP  = 1_500_000,
    parameter int T_WR_WAIT  = uart_lcd_pkg::T_WAIT_WR,
    parameter int T_CLR_WAIT = uart_lcd_pkg::T_WAIT_CLR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RXD,
    output logic [7:0] DB,
    output logic       E,
    output logic       RW,
    output logic       RS
);
    import uart_lcd_pkg::*;

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

    logic [7:0]  rx_data, pend_data;
    logic        rx_valid, pend_vld, pend_take;
    lcd_state_t  state, state_n;
    logic [31:0] cnt, cnt_n, wait_len, wait_len_n;
    logic [1:0]  init_idx, init_idx_n;
    logic        init_done, init_done_n;
    logic [4:0]  col, col_n;
    logic        line_pend, line_pend_n;
    logic [7:0]  db_n;
    logic        rs_n, e_n;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk   (clk),
        .reset (reset),
        .rxd   (RXD),
        .data  (rx_data),
        .valid (rx_valid)
    );

    assign RW = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PWRUP;
            cnt       <= '0;
            wait_len  <= '0;
            init_idx  <= '0;
            init_done <= 1'b0;
            col       <= '0;
            line_pend <= 1'b0;
            DB        <= 8'h00;
            RS        <= 1'b0;
            E         <= 1'b0;
            pend_vld  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            wait_len  <= wait_len_n;
            init_idx  <= init_idx_n;
            init_done <= init_done_n;
            col       <= col_n;
            line_pend <= line_pend_n;
            DB        <= db_n;
            RS        <= rs_n;
            E         <= e_n;
            // A byte landing on the same cycle the old one is taken must survive
            if (rx_valid)
                pend_vld <= 1'b1;
            else if (pend_take)
                pend_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_valid)
            pend_data <= rx_data;
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        wait_len_n  = wait_len;
        init_idx_n  = init_idx;
        init_done_n = init_done;
        col_n       = col;
        line_pend_n = line_pend;
        db_n        = DB;
        rs_n        = RS;
        e_n         = 1'b0;
        pend_take   = 1'b0;
        case (state)
            PWRUP: begin
                cnt_n = cnt + 32'd1;
                if (cnt == 32'(T_POWERUP - 1)) begin
                    cnt_n   = '0;
                    state_n = INIT_CMD;
                end
            end
            INIT_CMD: begin
                db_n       = init_cmd(init_idx);
                rs_n       = 1'b0;
                wait_len_n = (init_idx == 2'd2) ? 32'(T_CLR_WAIT) : 32'(T_WR_WAIT);
                cnt_n      = '0;
                state_n    = WR_SETUP;
            end
            WR_SETUP: begin
                cnt_n = cnt + 32'd1;
                if (cnt == 32'(T_SETUP - 1)) begin
                    cnt_n   = '0;
                    e_n     = 1'b1;
                    state_n = WR_PULSE;
                end
            end
            WR_PULSE: begin
                e_n   = 1'b1;
                cnt_n = cnt + 32'd1;
                if (cnt == 32'(T_PULSE - 1)) begin
                    cnt_n   = '0;
                    e_n     = 1'b0;
                    state_n = WR_HOLD;
                end
            end
            WR_HOLD: begin
                cnt_n = cnt + 32'd1;
                if (cnt == 32'(T_HOLD - 1)) begin
                    cnt_n   = '0;
                    state_n = WR_WAIT;
                end
            end
            WR_WAIT: begin
                cnt_n = cnt + 32'd1;
                if (cnt == wait_len - 32'd1) begin
                    cnt_n = '0;
                    if (init_done) begin
                        state_n = IDLE;
                    end else if (init_idx == 2'd3) begin
                        init_done_n = 1'b1;
                        state_n     = IDLE;
                    end else begin
                        init_idx_n = init_idx + 2'd1;
                        state_n    = INIT_CMD;
                    end
                end
            end
            // line_pend marks that the next character starts a new line
            IDLE: begin
                if (pend_vld) begin
                    if (line_pend) begin
                        state_n = LINE_CMD;
                    end else begin
                        db_n        = pend_data;
                        rs_n        = 1'b1;
                        pend_take   = 1'b1;
                        line_pend_n = (col == 5'd15) || (col == 5'd31);
                        col_n       = col + 5'd1;
                        wait_len_n  = 32'(T_WR_WAIT);
                        cnt_n       = '0;
                        state_n     = WR_SETUP;
                    end
                end
            end
            default: begin
                db_n        = (col == 5'd0) ? CMD_LINE1 : CMD_LINE2;
                rs_n        = 1'b0;
                line_pend_n = 1'b0;
                wait_len_n  = 32'(T_WR_WAIT);
                cnt_n       = '0;
                state_n     = WR_SETUP;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_zu_lcd.sv
// Directed bench for uart_zu_lcd with shortened timing: init sequence, byte
// reception, framing/glitch rejection, reset during a write, line changes.
module tb_uart_zu_lcd;

    localparam int CPB   = 16;
    localparam int T_PWR = 200;
    localparam int T_WR  = 100;
    localparam int T_CLR = 300;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       RXD = 1'b1;
    logic [7:0] DB;
    logic       E, RW, RS;

    typedef struct {
        logic [7:0] db;
        logic       rs;
        logic       rw;
        int         width;
        longint     rise;
        logic       stable;
    } wr_t;

    wr_t    writes[$];
    wr_t    cur;
    logic   e_q = 1'b0;
    longint cyc = 0;
    longint rel = 0;
    int     n_cmp = 0;
    int     n_fail = 0;

    logic [7:0] exp_init [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    int         exp_gap  [3] = '{T_WR + 61, T_WR + 61, T_CLR + 61};

    uart_zu_lcd #(
        .CLK_HZ(CPB * 10), .BAUD(10), .T_POWERUP(T_PWR),
        .T_WR_WAIT(T_WR), .T_CLR_WAIT(T_CLR)
    ) dut (
        .clk(clk), .reset(reset), .RXD(RXD),
        .DB(DB), .E(E), .RW(RW), .RS(RS)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Record each E pulse: bus values at rise, width, and bus stability
    initial forever begin
        @(negedge clk);
        if (E === 1'b1 && e_q !== 1'b1) begin
            cur.db = DB; cur.rs = RS; cur.rw = RW;
            cur.width = 1; cur.rise = cyc; cur.stable = 1'b1;
        end else if (E === 1'b1) begin
            cur.width = cur.width + 1;
            if (DB !== cur.db || RS !== cur.rs) cur.stable = 1'b0;
        end else if (e_q === 1'b1) begin
            writes.push_back(cur);
        end
        e_q = E;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        RXD = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (CPB) @(negedge clk);
        end
        RXD = stop;
        repeat (CPB) @(negedge clk);
        RXD = 1'b1;
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int i = 0; i < budget && writes.size() < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++; if (DB !== 8'h00) begin n_fail++; $display("FAIL reset_db: got %h expected 00", DB); end
        n_cmp++; if (E !== 1'b0) begin n_fail++; $display("FAIL reset_e: got %b expected 0", E); end
        n_cmp++; if (RS !== 1'b0) begin n_fail++; $display("FAIL reset_rs: got %b expected 0", RS); end
        n_cmp++; if (RW !== 1'b0) begin n_fail++; $display("FAIL reset_rw: got %b expected 0", RW); end
    endtask

    task automatic test_init();
        reset = 1'b0;
        rel = cyc;
        writes.delete();
        repeat (50) @(negedge clk);
        send_byte(8'h55, 1'b1);
        wait_writes(5, 3000);
        n_cmp++; if (writes.size() < 4) begin n_fail++; $display("FAIL init_count: got %0d expected >=4", writes.size()); end
        for (int i = 0; i < 4 && i < writes.size(); i++) begin
            n_cmp++;
            if (writes[i].db !== exp_init[i] || writes[i].rs !== 1'b0 || writes[i].rw !== 1'b0) begin
                n_fail++;
                $display("FAIL init_cmd%0d: got db=%h rs=%b rw=%b expected db=%h rs=0 rw=0",
                         i, writes[i].db, writes[i].rs, writes[i].rw, exp_init[i]);
            end
            n_cmp++;
            if (writes[i].width !== 50 || writes[i].stable !== 1'b1) begin
                n_fail++;
                $display("FAIL init_pulse%0d: got width=%0d stable=%b expected 50/1", i, writes[i].width, writes[i].stable);
            end
        end
        if (writes.size() >= 4) begin
            n_cmp++;
            if (writes[0].rise - rel !== longint'(T_PWR + 6)) begin
                n_fail++;
                $display("FAIL init_first: got %0d expected %0d", writes[0].rise - rel, T_PWR + 6);
            end
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (writes[i+1].rise - writes[i].rise !== longint'(exp_gap[i])) begin
                    n_fail++;
                    $display("FAIL init_gap%0d: got %0d expected %0d", i, writes[i+1].rise - writes[i].rise, exp_gap[i]);
                end
            end
        end
    endtask

    task automatic test_early_byte();
        repeat (400) @(negedge clk);
        n_cmp++; if (writes.size() !== 5) begin n_fail++; $display("FAIL early_count: got %0d expected 5", writes.size()); end
        if (writes.size() >= 5) begin
            n_cmp++;
            if (writes[4].db !== 8'h55 || writes[4].rs !== 1'b1 || writes[4].rw !== 1'b0 || writes[4].width !== 50) begin
                n_fail++;
                $display("FAIL early_data: got db=%h rs=%b rw=%b w=%0d expected 55/1/0/50",
                         writes[4].db, writes[4].rs, writes[4].rw, writes[4].width);
            end
        end
    endtask

    task automatic test_framing();
        writes.delete();
        send_byte(8'h33, 1'b0);
        repeat (500) @(negedge clk);
        n_cmp++; if (writes.size() !== 0) begin n_fail++; $display("FAIL framing: got %0d writes expected 0", writes.size()); end
    endtask

    task automatic test_glitch();
        writes.delete();
        RXD = 1'b0;
        repeat (4) @(negedge clk);
        RXD = 1'b1;
        repeat (400) @(negedge clk);
        n_cmp++; if (writes.size() !== 0) begin n_fail++; $display("FAIL glitch: got %0d writes expected 0", writes.size()); end
        send_byte(8'h7A, 1'b1);
        wait_writes(1, 600);
        n_cmp++; if (writes.size() !== 1) begin n_fail++; $display("FAIL post_glitch_count: got %0d expected 1", writes.size()); end
        if (writes.size() >= 1) begin
            n_cmp++;
            if (writes[0].db !== 8'h7A || writes[0].rs !== 1'b1) begin
                n_fail++; $display("FAIL post_glitch_data: got db=%h rs=%b expected 7a/1", writes[0].db, writes[0].rs);
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        int k;
        writes.delete();
        send_byte(8'h20, 1'b1);
        k = 0;
        while (E !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
        n_cmp++; if (E !== 1'b1) begin n_fail++; $display("FAIL mid_e_rise: got %b expected 1", E); end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (DB !== 8'h20 || RS !== 1'b1 || E !== 1'b1) begin
            n_fail++; $display("FAIL mid_bus: got db=%h rs=%b e=%b expected 20/1/1", DB, RS, E);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (E !== 1'b0 || DB !== 8'h00 || RS !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got e=%b db=%h rs=%b expected 0/00/0", E, DB, RS);
        end
        repeat (9) @(negedge clk);
        reset = 1'b0;
        rel = cyc;
        writes.delete();
        wait_writes(4, 2000);
        n_cmp++; if (writes.size() !== 4) begin n_fail++; $display("FAIL restart_count: got %0d expected 4", writes.size()); end
        for (int i = 0; i < 4 && i < writes.size(); i++) begin
            n_cmp++;
            if (writes[i].db !== exp_init[i] || writes[i].rs !== 1'b0) begin
                n_fail++; $display("FAIL restart_cmd%0d: got %h/%b expected %h/0", i, writes[i].db, writes[i].rs, exp_init[i]);
            end
        end
        if (writes.size() >= 1) begin
            n_cmp++;
            if (writes[0].rise - rel !== longint'(T_PWR + 6)) begin
                n_fail++; $display("FAIL restart_first: got %0d expected %0d", writes[0].rise - rel, T_PWR + 6);
            end
        end
        repeat (300) @(negedge clk);
    endtask

    task automatic test_line2();
        writes.delete();
        for (int b = 8'h41; b <= 8'h51; b++) begin
            send_byte(8'(b), 1'b1);
            repeat (200) @(negedge clk);
        end
        repeat (400) @(negedge clk);
        n_cmp++; if (writes.size() !== 18) begin n_fail++; $display("FAIL line2_count: got %0d expected 18", writes.size()); end
        for (int i = 0; i < 18 && i < writes.size(); i++) begin
            logic [7:0] ed;
            logic       er;
            ed = (i < 16) ? 8'(8'h41 + i) : ((i == 16) ? 8'hC0 : 8'h51);
            er = (i == 16) ? 1'b0 : 1'b1;
            n_cmp++;
            if (writes[i].db !== ed || writes[i].rs !== er) begin
                n_fail++; $display("FAIL line2_w%0d: got %h/%b expected %h/%b", i, writes[i].db, writes[i].rs, ed, er);
            end
        end
    endtask

    task automatic test_wrap();
        writes.delete();
        for (int b = 8'h52; b <= 8'h61; b++) begin
            send_byte(8'(b), 1'b1);
            repeat (200) @(negedge clk);
        end
        repeat (400) @(negedge clk);
        n_cmp++; if (writes.size() !== 17) begin n_fail++; $display("FAIL wrap_count: got %0d expected 17", writes.size()); end
        for (int i = 13; i < 17 && i < writes.size(); i++) begin
            logic [7:0] ed;
            logic       er;
            ed = (i < 15) ? 8'(8'h52 + i) : ((i == 15) ? 8'h80 : 8'h61);
            er = (i == 15) ? 1'b0 : 1'b1;
            n_cmp++;
            if (writes[i].db !== ed || writes[i].rs !== er) begin
                n_fail++; $display("FAIL wrap_w%0d: got %h/%b expected %h/%b", i, writes[i].db, writes[i].rs, ed, er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_early_byte();
        test_framing();
        test_glitch();
        test_reset_mid_pulse();
        test_line2();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
